// File: rtl/child_response_collector_if.sv
// Response bus between a parent collector and its children/upstream consumer.
// slave = the collector itself, master = the environment driving children and upstream ready.
interface child_response_collector_if #(
  parameter int N_CHILD = 5,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 3
);
  logic [N_CHILD-1:0]        child_valid;
  logic [N_CHILD*DATA_W-1:0] child_data;
  logic [N_CHILD-1:0]        child_ready;
  logic                      up_valid;
  logic                      up_ready;
  logic [DATA_W-1:0]         up_data;
  logic [IDX_W-1:0]          up_idx;
  logic [15:0]               fwd_count;

  modport slave (
    input  child_valid, child_data, up_ready,
    output child_ready, up_valid, up_data, up_idx, fwd_count
  );

  modport master (
    output child_valid, child_data, up_ready,
    input  child_ready, up_valid, up_data, up_idx, fwd_count
  );
endinterface

// File: rtl/child_response_collector.sv
// Round-robin collector of N_CHILD valid/ready response streams into one registered,
// index-tagged upstream stream, with a saturating forwarded-response counter.

module crc_lane #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3,
  parameter int LANE   = 0
) (
  input  logic              en_i,
  input  logic [IDX_W-1:0]  gnt_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o
);
  logic sel;
  assign sel     = (gnt_i == IDX_W'(LANE));
  assign ready_o = en_i && sel;
  // Zero unselected lanes so the top can OR-reduce instead of building a wide mux
  assign data_o  = sel ? data_i : '0;
endmodule

module child_response_collector #(
  parameter int N_CHILD = 5,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 3
) (
  input  logic clk,
  input  logic rst,
  child_response_collector_if.slave bus
);
  logic                           up_valid_q, up_valid_d;
  logic [DATA_W-1:0]              up_data_q, up_data_d;
  logic [IDX_W-1:0]               up_idx_q, up_idx_d;
  logic [IDX_W-1:0]               last_grant_q, last_grant_d;
  logic [15:0]                    fwd_count_q, fwd_count_d;

  logic                           load, any_vld, take;
  logic [IDX_W-1:0]               gnt;
  logic [N_CHILD-1:0]             lane_rdy;
  logic [N_CHILD-1:0][DATA_W-1:0] lane_data;
  logic [DATA_W-1:0]              gnt_data;

  assign load = !up_valid_q || bus.up_ready;

  // Search starts one past the last grant, so the previous winner has lowest priority
  always_comb begin
    any_vld = 1'b0;
    gnt     = '0;
    for (int k = 1; k <= N_CHILD; k++) begin
      int c;
      c = (int'(last_grant_q) + k) % N_CHILD;
      if (!any_vld && bus.child_valid[c]) begin
        any_vld = 1'b1;
        gnt     = IDX_W'(c);
      end
    end
  end

  assign take = load && any_vld && !rst;

  for (genvar i = 0; i < N_CHILD; i++) begin : g_lane
    crc_lane #(.DATA_W(DATA_W), .IDX_W(IDX_W), .LANE(i)) u_lane (
      .en_i    (take),
      .gnt_i   (gnt),
      .data_i  (bus.child_data[i*DATA_W +: DATA_W]),
      .ready_o (lane_rdy[i]),
      .data_o  (lane_data[i])
    );
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_CHILD; i++) gnt_data |= lane_data[i];
  end

  always_comb begin
    up_valid_d   = up_valid_q;
    up_data_d    = up_data_q;
    up_idx_d     = up_idx_q;
    last_grant_d = last_grant_q;
    fwd_count_d  = fwd_count_q;
    if (load) begin
      up_valid_d = any_vld;
      if (any_vld) begin
        up_data_d    = gnt_data;
        up_idx_d     = gnt;
        last_grant_d = gnt;
      end
    end
    if (up_valid_q && bus.up_ready && fwd_count_q != 16'hFFFF)
      fwd_count_d = fwd_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_valid_q   <= 1'b0;
      up_data_q    <= '0;
      up_idx_q     <= '0;
      last_grant_q <= IDX_W'(N_CHILD - 1);
      fwd_count_q  <= '0;
    end else begin
      up_valid_q   <= up_valid_d;
      up_data_q    <= up_data_d;
      up_idx_q     <= up_idx_d;
      last_grant_q <= last_grant_d;
      fwd_count_q  <= fwd_count_d;
    end
  end

  assign bus.child_ready = lane_rdy;
  assign bus.up_valid    = up_valid_q;
  assign bus.up_data     = up_data_q;
  assign bus.up_idx      = up_idx_q;
  assign bus.fwd_count   = fwd_count_q;
endmodule

// File: tb/tb_child_response_collector.sv
// Directed bench for child_response_collector: grant order, backpressure, drop, saturation, reset.
module tb_child_response_collector;
  localparam int N = 5, DW = 32, IW = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  child_response_collector_if #(.N_CHILD(N), .DATA_W(DW), .IDX_W(IW)) bus ();

  child_response_collector #(.N_CHILD(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] dat(input int i);
    return 32'hC0DE_0000 | DW'(i);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.child_valid = '1;
    bus.up_ready    = 1'b0;
    bus.child_data  = '0;
    for (int i = 0; i < N; i++) bus.child_data[i*DW +: DW] = dat(i);

    // reset state, children valid but nothing may be accepted
    tick(); tick();
    chk("rst_ready", bus.child_ready, 0);
    chk("rst_valid", bus.up_valid, 0);
    chk("rst_data", bus.up_data, 0);
    chk("rst_idx", bus.up_idx, 0);
    chk("rst_count", bus.fwd_count, 0);

    // single response from child 2
    rst = 1'b0;
    bus.child_valid = 5'b00100;
    bus.child_data[2*DW +: DW] = 32'hA5A5_0002;
    bus.up_ready = 1'b1;
    #1 chk("t1_ready", bus.child_ready, 5'b00100);
    tick();
    bus.child_valid = '0;
    bus.child_data[2*DW +: DW] = dat(2);
    chk("t1_valid", bus.up_valid, 1);
    chk("t1_data", bus.up_data, 32'hA5A5_0002);
    chk("t1_idx", bus.up_idx, 2);
    tick();
    chk("t1_count", bus.fwd_count, 1);
    chk("t1_idle", bus.up_valid, 0);

    // round robin at full throughput from a fresh reset
    do_reset();
    bus.child_valid = '1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("rr_valid%0d", i), bus.up_valid, 1);
      chk($sformatf("rr_idx%0d", i), bus.up_idx, i % N);
      chk($sformatf("rr_data%0d", i), bus.up_data, dat(i % N));
      if (i == 9) bus.child_valid = '0;
      tick();
    end
    chk("rr_count", bus.fwd_count, 10);
    chk("rr_idle", bus.up_valid, 0);

    // backpressure: child 1 accepted, then child 3 waits behind a stall
    bus.up_ready = 1'b0;
    bus.child_valid = 5'b01010;
    #1 chk("bp_ready1", bus.child_ready, 5'b00010);
    tick();
    bus.child_valid = 5'b01000;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("bp_stall_rdy%0d", i), bus.child_ready, 0);
      chk($sformatf("bp_stall_idx%0d", i), bus.up_idx, 1);
      chk($sformatf("bp_stall_data%0d", i), bus.up_data, dat(1));
      tick();
    end
    chk("bp_held_valid", bus.up_valid, 1);
    bus.up_ready = 1'b1;
    #1 chk("bp_release_rdy", bus.child_ready, 5'b01000);
    tick();
    bus.child_valid = '0;
    chk("bp_next_idx", bus.up_idx, 3);
    chk("bp_next_data", bus.up_data, dat(3));
    tick();

    // child 4 raises valid only while the output is stalled, then withdraws
    bus.up_ready = 1'b0;
    bus.child_valid = 5'b00001;
    tick();
    chk("drop_idx0", bus.up_idx, 0);
    bus.child_valid = 5'b10001;
    #1 chk("drop_rdy_a", bus.child_ready, 0);
    tick();
    chk("drop_rdy_b", bus.child_ready, 0);
    bus.child_valid = 5'b00001;
    bus.up_ready = 1'b1;
    #1 chk("drop_rdy_c", bus.child_ready, 5'b00001);
    tick();
    bus.child_valid = '0;
    chk("drop_idx_after", bus.up_idx, 0);
    chk("drop_data_after", bus.up_data, dat(0));
    tick();

    // counter saturation
    bus.child_valid = 5'b00001;
    repeat (65540) tick();
    bus.child_valid = '0;
    tick();
    chk("sat_count", bus.fwd_count, 16'hFFFF);

    // reset while a word is held
    bus.up_ready = 1'b0;
    bus.child_valid = 5'b00100;
    tick();
    chk("mrst_held", bus.up_valid, 1);
    rst = 1'b1;
    bus.child_valid = '1;
    #1 chk("mrst_ready", bus.child_ready, 0);
    tick();
    rst = 1'b0;
    chk("mrst_valid", bus.up_valid, 0);
    chk("mrst_count", bus.fwd_count, 0);
    bus.up_ready = 1'b1;
    #1 chk("mrst_gnt", bus.child_ready, 5'b00001);
    tick();
    chk("mrst_idx", bus.up_idx, 0);
    bus.child_valid = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
